vending_machine_multi: RTL and testbench
========================================

# vending_machine_multi

Parametrised multi-product vending controller: it accepts nickel/dime/quarter pulses and holds a bounded credit. It vends one of `NUM_ITEMS` products at per-item prices. Change is paid out as a serial stream of physical coins, largest coin first, one coin per cycle. It supersedes the single-price, lump-change controller and sits between the coin-acceptor front end and the dispenser/coin-hopper drivers.

## Interface
- `NUM_ITEMS`, 4: number of selectable products (1..16).
- `VAL_W`, 8: width of credit and price values, in cents.
- `MAX_CREDIT`, 100: highest credit the machine will hold; must be a multiple of 5 and < 2^VAL_W.
- `ITEM_PRICES`, {8'd50, 8'd45, 8'd35, 8'd25}: packed `NUM_ITEMS*VAL_W` vector; item i is at bits [i*VAL_W +: VAL_W]. Each price must be a nonzero multiple of 5 and ≤ MAX_CREDIT; an elaboration check enforces this.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `nickel`, `dime`, `quarter` in 1 each: single-cycle coin pulses.
- `sel_valid` in 1: product select strobe.
- `sel_idx` in $clog2(NUM_ITEMS): product index, sampled with `sel_valid`.
- `cancel` in 1: refund request.
- `sold_out` in NUM_ITEMS: per-item empty flags.
- `credit` out VAL_W: current credit.
- `busy` out 1: high in VEND or CHANGE.
- `coin_reject` out 1: one-cycle pulse; the coin was not credited.
- `sel_err` out 1: one-cycle pulse; the select was refused.
- `dispense` out 1: one-cycle vend pulse.
- `dispense_idx` out $clog2(NUM_ITEMS): item vended; valid while `dispense` is high.
- `coin_out_valid` out 1: change coin this cycle.
- `coin_out_type` out 2: 01 = nickel, 10 = dime, 11 = quarter, 00 = none.
- `change_done` out 1: high in the cycle of the last change coin.

## Operation
- States:
  - IDLE (credit = 0)
  - CREDIT (credit > 0)
  - VEND (one cycle)
  - CHANGE (one coin per cycle)
- Coins, IDLE/CREDIT only:
  - If exactly one coin line is high and credit + value ≤ MAX_CREDIT: add the value and go to CREDIT.
  - If more than one coin line is high, or the overflow check fails: `coin_reject` pulses and credit is unchanged.
  - Any coin arriving in VEND/CHANGE: `coin_reject` pulses.
- Select, IDLE/CREDIT:
  - If sel_idx < NUM_ITEMS, `sold_out[sel_idx]` = 0 and credit ≥ price: go to VEND and subtract the price.
  - Otherwise `sel_err` pulses and the state is unchanged.
- VEND: `dispense` = 1 and `dispense_idx` = the latched index. Next state is CHANGE if the remaining credit > 0, else IDLE.
- Cancel in CREDIT: go to CHANGE. Cancel in IDLE: no effect.
- CHANGE, every cycle:
  - `coin_out_valid` = 1.
  - The coin type is chosen greedily from the credit register: quarter if ≥ 25, else dime if ≥ 10, else nickel.
  - Credit decreases by that coin's value at the cycle's closing edge.
  - When the post-decrement value is 0: `change_done` = 1 that cycle, then go to IDLE.
- Simultaneous events:
  - Cancel and select together: cancel wins and the select is ignored (no `sel_err`).
  - Coin together with an accepted select or cancel: the coin is rejected.
  - Coin together with a refused select: the coin is processed normally and `sel_err` still pulses.
- Arithmetic: credit is always a multiple of 5. Comparisons are unsigned at VAL_W+1 bits so the overflow check cannot wrap.

## Timing
- Inputs are sampled on the rising edge. All outputs are registered, or decoded from registered state/credit only.
- A coin sampled at edge N shows in `credit` after edge N. `coin_reject` and `sel_err` are high during cycle N+1.
- A select accepted at edge N gives `dispense` during cycle N+1. The first change coin comes in cycle N+2.
- The number of change cycles equals the greedy coin count. Example: 15¢ is a dime then a nickel, over 2 cycles.
- Reset, at any time including mid-CHANGE: state IDLE, credit 0, every output 0. Any unpaid credit is forfeited.

## Structure
- Package `vm_pkg` holds:
  - coin value constants: 5, 10, 25
  - the `coin_type_t` 2-bit encoding
  - the state enum
- Sub-module `vm_change_picker`: combinational. It takes credit and returns the greedy coin type and coin value, and is reused by the CHANGE-state logic.

## Test plan
- Dime, then quarter, then select item 1 (35¢): `dispense` with idx 1 one cycle after the select, no coins out, back in IDLE, credit 0.
- Two quarters, then select item 1 (35¢): dispense, then a dime in cycle +2 and a nickel in cycle +3 with `change_done`, then IDLE.
- Credit 90, then a quarter: `coin_reject`, credit stays 90. Nickel and dime in the same cycle: `coin_reject`, credit unchanged.
- Credit 30, select item 3 (50¢): `sel_err`, credit 30. Select item 0 while `sold_out[0]` = 1: `sel_err`.
- Credit 40, cancel and select in the same cycle: refund of a quarter, a dime, then a nickel over 3 cycles, no dispense. A coin arriving during CHANGE is rejected.
- `rst_n` low in the middle of CHANGE: the next cycle shows credit 0, `coin_out_valid` 0, IDLE.

Source files
------------

// File: rtl/vending_machine_multi_pkg.sv
// Shared coin constants, change-coin encoding and controller state for the
// multi-product vending controller.
package vm_pkg;

  localparam int unsigned COIN_NICKEL  = 5;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_QUARTER = 25;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_N    = 2'b01,
    COIN_D    = 2'b10,
    COIN_Q    = 2'b11
  } coin_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CREDIT = 2'b01,
    ST_VEND   = 2'b10,
    ST_CHANGE = 2'b11
  } state_t;

endpackage

// File: rtl/vending_machine_multi_change_picker.sv
// Greedy change-coin selector: largest physical coin not exceeding the credit.
// Returns a nickel for anything below a dime; callers mask it when not paying out.
module vm_change_picker
  import vm_pkg::*;
#(
  parameter int VAL_W = 8
) (
  input  logic [VAL_W-1:0] credit_i,
  output coin_type_t       coin_type_o,
  output logic [VAL_W-1:0] coin_val_o
);

  logic [VAL_W:0] credit_ext_s;
  assign credit_ext_s = {1'b0, credit_i};

  // Largest-coin-first choice
  always_comb begin
    coin_type_o = COIN_N;
    coin_val_o  = VAL_W'(COIN_NICKEL);
    if (credit_ext_s >= (VAL_W+1)'(COIN_QUARTER)) begin
      coin_type_o = COIN_Q;
      coin_val_o  = VAL_W'(COIN_QUARTER);
    end else if (credit_ext_s >= (VAL_W+1)'(COIN_DIME)) begin
      coin_type_o = COIN_D;
      coin_val_o  = VAL_W'(COIN_DIME);
    end else begin
      coin_type_o = COIN_N;
      coin_val_o  = VAL_W'(COIN_NICKEL);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: bounded credit from coin pulses, per-item
// prices, and change paid out serially one greedy coin per cycle.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                          NUM_ITEMS   = 4,
  parameter int                          VAL_W       = 8,
  parameter int                          MAX_CREDIT  = 100,
  parameter logic [NUM_ITEMS*VAL_W-1:0]  ITEM_PRICES = {8'd50, 8'd45, 8'd35, 8'd25},
  localparam int                         IDX_W       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 nickel,
  input  logic                 dime,
  input  logic                 quarter,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  input  logic                 cancel,
  input  logic [NUM_ITEMS-1:0] sold_out,
  output logic [VAL_W-1:0]     credit,
  output logic                 busy,
  output logic                 coin_reject,
  output logic                 sel_err,
  output logic                 dispense,
  output logic [IDX_W-1:0]     dispense_idx,
  output logic                 coin_out_valid,
  output logic [1:0]           coin_out_type,
  output logic                 change_done
);

  if (NUM_ITEMS < 1 || NUM_ITEMS > 16) begin : g_bad_items
    $error("vending_machine_multi: NUM_ITEMS must be 1..16");
  end
  if ((MAX_CREDIT % 5) != 0 || MAX_CREDIT >= (1 << VAL_W)) begin : g_bad_max
    $error("vending_machine_multi: MAX_CREDIT must be a multiple of 5 below 2^VAL_W");
  end
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price_chk
    if (ITEM_PRICES[gi*VAL_W +: VAL_W] == '0 ||
        (int'(ITEM_PRICES[gi*VAL_W +: VAL_W]) % 5) != 0 ||
        int'(ITEM_PRICES[gi*VAL_W +: VAL_W]) > MAX_CREDIT) begin : g_bad_price
      $error("vending_machine_multi: each price must be a nonzero multiple of 5 <= MAX_CREDIT");
    end
  end

  state_t           state_q, state_d;
  logic [VAL_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             coin_reject_q, coin_reject_d;
  logic             sel_err_q, sel_err_d;

  coin_type_t       pick_type_s;
  logic [VAL_W-1:0] pick_val_s;

  vm_change_picker #(.VAL_W(VAL_W)) u_picker (
    .credit_i    (credit_q),
    .coin_type_o (pick_type_s),
    .coin_val_o  (pick_val_s)
  );

  logic [1:0]       coin_cnt_s;
  logic [VAL_W:0]   coin_val_s;
  logic [VAL_W:0]   coin_sum_s;
  logic [VAL_W-1:0] price_s;
  logic             sold_s;
  logic             in_range_s;
  logic             open_s;
  logic             cancel_take_s;
  logic             sel_ok_s;
  logic             sel_take_s;
  logic             sel_refuse_s;
  logic             coin_ok_s;

  // Price and sold-out lookup without indexing out of range
  always_comb begin
    price_s = '0;
    sold_s  = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      price_s = (sel_idx == IDX_W'(i)) ? ITEM_PRICES[i*VAL_W +: VAL_W] : price_s;
      sold_s  = (sel_idx == IDX_W'(i)) ? sold_out[i] : sold_s;
    end
  end

  assign coin_cnt_s = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
  assign coin_val_s = quarter ? (VAL_W+1)'(COIN_QUARTER) :
                      dime    ? (VAL_W+1)'(COIN_DIME)    :
                      nickel  ? (VAL_W+1)'(COIN_NICKEL)  : '0;
  assign coin_sum_s = {1'b0, credit_q} + coin_val_s;
  assign in_range_s = {1'b0, sel_idx} < (IDX_W+1)'(NUM_ITEMS);
  assign open_s     = (state_q == ST_IDLE) || (state_q == ST_CREDIT);

  // Cancel outranks select, and an accepted select or cancel swallows any coin
  assign cancel_take_s = (state_q == ST_CREDIT) && cancel;
  assign sel_ok_s      = in_range_s && !sold_s && ({1'b0, credit_q} >= {1'b0, price_s});
  assign sel_take_s    = open_s && !cancel_take_s && sel_valid && sel_ok_s;
  assign sel_refuse_s  = open_s && !cancel_take_s && sel_valid && !sel_ok_s;
  assign coin_ok_s     = open_s && !cancel_take_s && !sel_take_s && (coin_cnt_s == 2'd1) &&
                         (coin_sum_s <= (VAL_W+1)'(MAX_CREDIT));

  // Next-state and next-credit decode
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    idx_d         = idx_q;
    coin_reject_d = (coin_cnt_s != 2'd0) && !coin_ok_s;
    sel_err_d     = sel_refuse_s;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel_take_s) begin
          state_d = ST_CHANGE;
        end else if (sel_take_s) begin
          state_d  = ST_VEND;
          credit_d = credit_q - price_s;
          idx_d    = sel_idx;
        end else if (coin_ok_s) begin
          state_d  = ST_CREDIT;
          credit_d = coin_sum_s[VAL_W-1:0];
        end else begin
          state_d = state_q;
        end
      end
      ST_VEND: begin
        state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        credit_d = credit_q - pick_val_s;
        state_d  = (credit_q == pick_val_s) ? ST_IDLE : ST_CHANGE;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Controller state and pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      idx_q         <= '0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      idx_q         <= idx_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign credit         = credit_q;
  assign busy           = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign coin_reject    = coin_reject_q;
  assign sel_err        = sel_err_q;
  assign dispense       = (state_q == ST_VEND);
  assign dispense_idx   = (state_q == ST_VEND) ? idx_q : '0;
  assign coin_out_valid = (state_q == ST_CHANGE);
  assign coin_out_type  = (state_q == ST_CHANGE) ? pick_type_s : COIN_NONE;
  assign change_done    = (state_q == ST_CHANGE) && (credit_q == pick_val_s);

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed table-driven bench for vending_machine_multi (prices 25/35/45/50, max credit 100).
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       nickel, dime, quarter, sel_valid, cancel;
  logic [1:0] sel_idx;
  logic [3:0] sold_out;
  logic [7:0] credit;
  logic       busy, coin_reject, sel_err, dispense, coin_out_valid, change_done;
  logic [1:0] dispense_idx, coin_out_type;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .sold_out(sold_out),
    .credit(credit), .busy(busy), .coin_reject(coin_reject), .sel_err(sel_err),
    .dispense(dispense), .dispense_idx(dispense_idx), .coin_out_valid(coin_out_valid),
    .coin_out_type(coin_out_type), .change_done(change_done)
  );

  // Inputs: n d q sv si cn so ; expected: credit busy rej err disp idx cov cot cdone
  typedef struct {
    string name;
    int n; int d; int q; int sv; int si; int cn; int so;
    int ec; int eb; int erj; int ee; int edp; int ei; int ecv; int ect; int ecd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] pack_out(input int c, input int b, input int rj, input int e,
                                           input int dp, input int ix, input int cv, input int ct,
                                           input int cd);
    logic [17:0] r;
    r = {c[7:0], b[0], rj[0], e[0], dp[0], ix[1:0], cv[0], ct[1:0], cd[0]};
    return r;
  endfunction

  function automatic logic [17:0] dut_out();
    return {credit, busy, coin_reject, sel_err, dispense, dispense_idx,
            coin_out_valid, coin_out_type, change_done};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d busy=%b rej=%b err=%b disp=%b idx=%0d cov=%b cot=%b done=%b, expected credit=%0d busy=%b rej=%b err=%b disp=%b idx=%0d cov=%b cot=%b done=%b",
               name, got[17:10], got[9], got[8], got[7], got[6], got[5:4], got[3], got[2:1], got[0],
               exp[17:10], exp[9], exp[8], exp[7], exp[6], exp[5:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic idle_inputs();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
    sel_valid = 1'b0; sel_idx = 2'd0; cancel = 1'b0; sold_out = 4'b0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input int n, input int d, input int q, input int sv,
                     input int si, input int cn, input int so, input int ec, input int eb,
                     input int erj, input int ee, input int edp, input int ei, input int ecv,
                     input int ect, input int ecd);
    vec_t v;
    v.name = nm; v.n = n; v.d = d; v.q = q; v.sv = sv; v.si = si; v.cn = cn; v.so = so;
    v.ec = ec; v.eb = eb; v.erj = erj; v.ee = ee; v.edp = edp; v.ei = ei;
    v.ecv = ecv; v.ect = ect; v.ecd = ecd;
    vecs.push_back(v);
  endtask

  initial begin
    //   name             n d q sv si cn so    cr b rj e dp ix cv ct cd
    add("dime",           0,1,0, 0,0, 0,0,    10, 0,0,0,0, 0, 0,0,0);
    add("quarter35",      0,0,1, 0,0, 0,0,    35, 0,0,0,0, 0, 0,0,0);
    add("sel1_exact",     0,0,0, 1,1, 0,0,     0, 1,0,0,1, 1, 0,0,0);
    add("back_idle",      0,0,0, 0,0, 0,0,     0, 0,0,0,0, 0, 0,0,0);
    add("q25",            0,0,1, 0,0, 0,0,    25, 0,0,0,0, 0, 0,0,0);
    add("q50",            0,0,1, 0,0, 0,0,    50, 0,0,0,0, 0, 0,0,0);
    add("sel1_change",    0,0,0, 1,1, 0,0,    15, 1,0,0,1, 1, 0,0,0);
    add("chg_dime",       0,0,0, 0,0, 0,0,    15, 1,0,0,0, 0, 1,2,0);
    add("chg_nickel",     0,0,0, 0,0, 0,0,     5, 1,0,0,0, 0, 1,1,1);
    add("idle_after_chg", 0,0,0, 0,0, 0,0,     0, 0,0,0,0, 0, 0,0,0);
    add("fill_q1",        0,0,1, 0,0, 0,0,    25, 0,0,0,0, 0, 0,0,0);
    add("fill_q2",        0,0,1, 0,0, 0,0,    50, 0,0,0,0, 0, 0,0,0);
    add("fill_q3",        0,0,1, 0,0, 0,0,    75, 0,0,0,0, 0, 0,0,0);
    add("fill_d",         0,1,0, 0,0, 0,0,    85, 0,0,0,0, 0, 0,0,0);
    add("fill_n",         1,0,0, 0,0, 0,0,    90, 0,0,0,0, 0, 0,0,0);
    add("overflow_q",     0,0,1, 0,0, 0,0,    90, 0,1,0,0, 0, 0,0,0);
    add("two_coins",      1,1,0, 0,0, 0,0,    90, 0,1,0,0, 0, 0,0,0);
    add("dime_to_max",    0,1,0, 0,0, 0,0,   100, 0,0,0,0, 0, 0,0,0);
    add("nickel_at_max",  1,0,0, 0,0, 0,0,   100, 0,1,0,0, 0, 0,0,0);
    add("cancel_100",     0,0,0, 0,0, 1,0,   100, 1,0,0,0, 0, 1,3,0);
    add("refund_q2",      0,0,0, 0,0, 0,0,    75, 1,0,0,0, 0, 1,3,0);
    add("refund_q3",      0,0,0, 0,0, 0,0,    50, 1,0,0,0, 0, 1,3,0);
    add("refund_q4",      0,0,0, 0,0, 0,0,    25, 1,0,0,0, 0, 1,3,1);
    add("refund_idle",    0,0,0, 0,0, 0,0,     0, 0,0,0,0, 0, 0,0,0);
    add("c30_q",          0,0,1, 0,0, 0,0,    25, 0,0,0,0, 0, 0,0,0);
    add("c30_n",          1,0,0, 0,0, 0,0,    30, 0,0,0,0, 0, 0,0,0);
    add("sel3_short",     0,0,0, 1,3, 0,0,    30, 0,0,1,0, 0, 0,0,0);
    add("sel0_soldout",   0,0,0, 1,0, 0,1,    30, 0,0,1,0, 0, 0,0,0);
    add("refused_sel_n",  1,0,0, 1,2, 0,0,    35, 0,0,1,0, 0, 0,0,0);
    add("c40_n",          1,0,0, 0,0, 0,0,    40, 0,0,0,0, 0, 0,0,0);
    add("cancel_and_sel", 0,0,0, 1,0, 1,0,    40, 1,0,0,0, 0, 1,3,0);
    add("coin_in_change", 0,1,0, 0,0, 0,0,    15, 1,1,0,0, 0, 1,2,0);
    add("refund_nickel",  0,0,0, 0,0, 0,0,     5, 1,0,0,0, 0, 1,1,1);
    add("refund40_idle",  0,0,0, 0,0, 0,0,     0, 0,0,0,0, 0, 0,0,0);
    add("sel_no_credit",  0,0,0, 1,0, 0,0,     0, 0,0,1,0, 0, 0,0,0);
    add("q_for_item0",    0,0,1, 0,0, 0,0,    25, 0,0,0,0, 0, 0,0,0);
    add("sel0_with_coin", 1,0,0, 1,0, 0,0,     0, 1,1,0,1, 0, 0,0,0);
    add("final_idle",     0,0,0, 0,0, 0,0,     0, 0,0,0,0, 0, 0,0,0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset_state", dut_out(), pack_out(0, 0,0,0,0, 0, 0,0,0));
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      nickel    = vecs[k].n[0];
      dime      = vecs[k].d[0];
      quarter   = vecs[k].q[0];
      sel_valid = vecs[k].sv[0];
      sel_idx   = vecs[k].si[1:0];
      cancel    = vecs[k].cn[0];
      sold_out  = vecs[k].so[3:0];
      tick();
      idle_inputs();
      check(vecs[k].name, dut_out(),
            pack_out(vecs[k].ec, vecs[k].eb, vecs[k].erj, vecs[k].ee, vecs[k].edp,
                     vecs[k].ei, vecs[k].ecv, vecs[k].ect, vecs[k].ecd));
    end

    // Reset asserted while change is being paid out forfeits the remaining credit
    repeat (3) begin
      quarter = 1'b1;
      tick();
    end
    quarter = 1'b0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("mid_chg_first", dut_out(), pack_out(75, 1,0,0,0, 0, 1,3,0));
    tick();
    check("mid_chg_second", dut_out(), pack_out(50, 1,0,0,0, 0, 1,3,0));
    rst_n = 1'b0;
    tick();
    check("reset_mid_change", dut_out(), pack_out(0, 0,0,0,0, 0, 0,0,0));
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", dut_out(), pack_out(0, 0,0,0,0, 0, 0,0,0));

    // Vend of item 2 from 50 leaves 5: single nickel with change_done
    quarter = 1'b1; tick(); tick();
    quarter = 1'b0;
    sel_valid = 1'b1; sel_idx = 2'd2;
    tick();
    idle_inputs();
    check("sel2_vend", dut_out(), pack_out(5, 1,0,0,1, 2, 0,0,0));
    tick();
    check("sel2_change", dut_out(), pack_out(5, 1,0,0,0, 0, 1,1,1));
    tick();
    check("sel2_idle", dut_out(), pack_out(0, 0,0,0,0, 0, 0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
